pixel_window_ctrl: RTL and testbench

PIXEL_WINDOW_CTRL -- requirements
Module: pixel_window_ctrl

---
 rtl/pixel_window_ctrl.sv | 138 +++++++++++++
 tb/tb_pixel_window_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_ctrl.sv
// Raster-scan window controller: counts incoming pixels of a square feature map and
// flags each pixel that completes a KERNEL_SIZE x KERNEL_SIZE window on the stride grid.
module pixel_window_ctrl #(
  parameter int IFM_SIZE    = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pixel_valid,
  output logic                 busy,
  output logic                 window_valid,
  output logic [CNT_WIDTH-1:0] out_row,
  output logic [CNT_WIDTH-1:0] out_col,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(IFM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] K1   = CNT_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] SM1  = CNT_WIDTH'(STRIDE - 1);
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_WIDTH-1:0] row_ph_q, row_ph_d, col_ph_q, col_ph_d;
  logic [CNT_WIDTH-1:0] row_idx_q, row_idx_d, col_idx_q, col_idx_d;
  logic [CNT_WIDTH-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic                 window_valid_q, window_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      row_ph_q       <= '0;
      col_ph_q       <= '0;
      row_idx_q      <= '0;
      col_idx_q      <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      window_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      row_ph_q       <= row_ph_d;
      col_ph_q       <= col_ph_d;
      row_idx_q      <= row_idx_d;
      col_idx_q      <= col_idx_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      window_valid_q <= window_valid_d;
    end
  end

  // Phase counters run from the first full-kernel position; phase 0 marks a stride hit
  // and the idx counters carry the matching output-map coordinate.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    row_ph_d       = row_ph_q;
    col_ph_d       = col_ph_q;
    row_idx_d      = row_idx_q;
    col_idx_d      = col_idx_q;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;
    window_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          row_d     = ZERO;
          col_d     = ZERO;
          row_ph_d  = ZERO;
          col_ph_d  = ZERO;
          row_idx_d = ZERO;
          col_idx_d = ZERO;
        end
      end
      RUN: begin
        if (pixel_valid) begin
          if (row_q >= K1 && col_q >= K1 && row_ph_q == ZERO && col_ph_q == ZERO) begin
            window_valid_d = 1'b1;
            out_row_d      = row_idx_q;
            out_col_d      = col_idx_q;
          end
          if (col_q == LAST) begin
            col_d     = ZERO;
            col_ph_d  = ZERO;
            col_idx_d = ZERO;
            if (row_q == LAST) begin
              state_d   = DONE;
              row_d     = ZERO;
              row_ph_d  = ZERO;
              row_idx_d = ZERO;
            end else begin
              row_d = row_q + ONE;
              if (row_q >= K1) begin
                if (row_ph_q == SM1) begin
                  row_ph_d  = ZERO;
                  row_idx_d = row_idx_q + ONE;
                end else begin
                  row_ph_d  = row_ph_q + ONE;
                end
              end
            end
          end else begin
            col_d = col_q + ONE;
            if (col_q >= K1) begin
              if (col_ph_q == SM1) begin
                col_ph_d  = ZERO;
                col_idx_d = col_idx_q + ONE;
              end else begin
                col_ph_d  = col_ph_q + ONE;
              end
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign window_valid = window_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Drives three controller instances (6/3/1, 6/3/2, 28/5/1) with shared stimulus and
// checks windows and frame ends through per-instance expectation queues.
module tb_pixel_window_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pixel_valid = 1'b0;

  logic       dbusy [3];
  logic       dwv   [3];
  logic       dfd   [3];
  logic [4:0] drow  [3];
  logic [4:0] dcol  [3];

  always #5 clk = ~clk;

  pixel_window_ctrl #(.IFM_SIZE(6), .KERNEL_SIZE(3), .STRIDE(1), .CNT_WIDTH(5)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pixel_valid(pixel_valid),
    .busy(dbusy[0]), .window_valid(dwv[0]), .out_row(drow[0]), .out_col(dcol[0]),
    .frame_done(dfd[0]));

  pixel_window_ctrl #(.IFM_SIZE(6), .KERNEL_SIZE(3), .STRIDE(2), .CNT_WIDTH(5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pixel_valid(pixel_valid),
    .busy(dbusy[1]), .window_valid(dwv[1]), .out_row(drow[1]), .out_col(dcol[1]),
    .frame_done(dfd[1]));

  pixel_window_ctrl dut_c (
    .clk(clk), .reset(reset), .start(start), .pixel_valid(pixel_valid),
    .busy(dbusy[2]), .window_valid(dwv[2]), .out_row(drow[2]), .out_col(dcol[2]),
    .frame_done(dfd[2]));

  typedef struct {
    int kind;   // 0 = window, 1 = frame_done
    int r;
    int c;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int pn [3] = '{6, 6, 28};
  int pk [3] = '{3, 3, 5};
  int ps [3] = '{1, 2, 1};

  int  ms [3] = '{0, 0, 0};
  int  mr [3] = '{0, 0, 0};
  int  mc [3] = '{0, 0, 0};
  logic exp_busy [3] = '{1'b0, 1'b0, 1'b0};
  int  last_r [3] = '{0, 0, 0};
  int  last_c [3] = '{0, 0, 0};
  int  cnt_wv [3] = '{0, 0, 0};
  int  base_wv[3] = '{0, 0, 0};

  int cyc_n = 0;
  int compared = 0;
  int mismatched = 0;

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpeek(input int d, output bit ok, output exp_t e);
    ok = 1'b0;
    e.kind = -1; e.r = 0; e.c = 0; e.cyc = 0;
    case (d)
      0: if (q0.size() > 0) begin ok = 1'b1; e = q0[0]; end
      1: if (q1.size() > 0) begin ok = 1'b1; e = q1[0]; end
      default: if (q2.size() > 0) begin ok = 1'b1; e = q2[0]; end
    endcase
  endtask

  task automatic qpop(input int d);
    case (d)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Reference model for one upcoming clock edge, using plain mod/div arithmetic.
  task automatic model(input int d, input bit r, input bit s, input bit p);
    exp_t e;
    int k1;
    k1 = pk[d] - 1;
    e.cyc = cyc_n + 1;
    if (r) begin
      ms[d] = 0; mr[d] = 0; mc[d] = 0;
      last_r[d] = 0; last_c[d] = 0;
    end else begin
      case (ms[d])
        0: if (s) begin ms[d] = 1; mr[d] = 0; mc[d] = 0; end
        1: if (p) begin
          if (mr[d] >= k1 && mc[d] >= k1 &&
              (mr[d] - k1) % ps[d] == 0 && (mc[d] - k1) % ps[d] == 0) begin
            e.kind = 0; e.r = (mr[d] - k1) / ps[d]; e.c = (mc[d] - k1) / ps[d];
            qpush(d, e);
          end
          if (mr[d] == pn[d] - 1 && mc[d] == pn[d] - 1) begin
            e.kind = 1; e.r = 0; e.c = 0;
            qpush(d, e);
            ms[d] = 2; mr[d] = 0; mc[d] = 0;
          end else if (mc[d] == pn[d] - 1) begin
            mc[d] = 0; mr[d] = mr[d] + 1;
          end else begin
            mc[d] = mc[d] + 1;
          end
        end
        default: ms[d] = 0;
      endcase
    end
    exp_busy[d] = (ms[d] != 0);
  endtask

  task automatic cyc(input bit r, input bit s, input bit p);
    @(negedge clk);
    reset = r; start = s; pixel_valid = p;
    for (int d = 0; d < 3; d++) model(d, r, s, p);
  endtask

  task automatic check(input int d);
    bit ok;
    exp_t e;
    compared++;
    if (dbusy[d] !== exp_busy[d]) begin
      mismatched++;
      $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc_n, dbusy[d], exp_busy[d]);
    end
    qpeek(d, ok, e);
    while (ok && e.cyc < cyc_n) begin
      compared++; mismatched++;
      $display("FAIL missed dut%0d cyc %0d: got nothing, want kind %0d (%0d,%0d) at cyc %0d",
               d, cyc_n, e.kind, e.r, e.c, e.cyc);
      qpop(d);
      qpeek(d, ok, e);
    end
    compared++;
    if (dwv[d] === 1'b1) begin
      cnt_wv[d]++;
      if (ok && e.kind == 0 && e.cyc == cyc_n) begin
        if (drow[d] !== 5'(e.r) || dcol[d] !== 5'(e.c)) begin
          mismatched++;
          $display("FAIL window_coord dut%0d cyc %0d: got (%0d,%0d) want (%0d,%0d)",
                   d, cyc_n, drow[d], dcol[d], e.r, e.c);
        end
        last_r[d] = e.r; last_c[d] = e.c;
        qpop(d);
      end else begin
        mismatched++;
        $display("FAIL window_unexpected dut%0d cyc %0d: got (%0d,%0d) want no window",
                 d, cyc_n, drow[d], dcol[d]);
      end
    end else if (drow[d] !== 5'(last_r[d]) || dcol[d] !== 5'(last_c[d])) begin
      mismatched++;
      $display("FAIL out_hold dut%0d cyc %0d: got (%0d,%0d) want (%0d,%0d)",
               d, cyc_n, drow[d], dcol[d], last_r[d], last_c[d]);
    end
    qpeek(d, ok, e);
    if (dfd[d] === 1'b1) begin
      compared++;
      if (ok && e.kind == 1 && e.cyc == cyc_n) begin
        qpop(d);
      end else begin
        mismatched++;
        $display("FAIL frame_done_unexpected dut%0d cyc %0d: got 1 want 0", d, cyc_n);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      for (int d = 0; d < 3; d++) check(d);
    end
  end

  task automatic expect_wins(input int d, input int want, input string name);
    compared++;
    if (cnt_wv[d] - base_wv[d] != want) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0d windows want %0d", name, d, cnt_wv[d] - base_wv[d], want);
    end
    base_wv[d] = cnt_wv[d];
  endtask

  task automatic expect_idle_zero(input int d, input string name);
    compared++;
    if (dbusy[d] !== 1'b0 || dwv[d] !== 1'b0 || dfd[d] !== 1'b0 ||
        drow[d] !== 5'd0 || dcol[d] !== 5'd0) begin
      mismatched++;
      $display("FAIL %s dut%0d: got busy=%b wv=%b fd=%b out=(%0d,%0d) want all 0",
               name, d, dbusy[d], dwv[d], dfd[d], drow[d], dcol[d]);
    end
  endtask

  task automatic frame_tail_and_reset();
    repeat (3) cyc(0, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int d = 0; d < 3; d++) expect_idle_zero(d, "reset_state");

    // Back-to-back frame.
    cyc(0, 1, 0);
    repeat (36) cyc(0, 0, 1);
    frame_tail_and_reset();
    $display("frame back-to-back: windows a=%0d b=%0d c=%0d", cnt_wv[0] - base_wv[0],
             cnt_wv[1] - base_wv[1], cnt_wv[2] - base_wv[2]);
    expect_wins(0, 16, "s1_frame");
    expect_wins(1, 4, "s2_frame");
    expect_wins(2, 0, "big_partial");
    repeat (2) cyc(1, 0, 0);

    // pixel_valid toggling each cycle.
    cyc(0, 1, 0);
    repeat (36) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    frame_tail_and_reset();
    $display("frame toggled: windows a=%0d b=%0d", cnt_wv[0] - base_wv[0], cnt_wv[1] - base_wv[1]);
    expect_wins(0, 16, "s1_toggle");
    expect_wins(1, 4, "s2_toggle");
    expect_wins(2, 0, "big_toggle");
    repeat (2) cyc(1, 0, 0);

    // Reset mid-frame after 20 pixels, then a full frame.
    cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int d = 0; d < 3; d++) expect_idle_zero(d, "midframe_reset");
    cyc(0, 1, 0);
    repeat (36) cyc(0, 0, 1);
    frame_tail_and_reset();
    $display("frame after reset: windows a=%0d b=%0d", cnt_wv[0] - base_wv[0], cnt_wv[1] - base_wv[1]);
    expect_wins(0, 20, "s1_reset_frame");
    expect_wins(1, 6, "s2_reset_frame");

    // Ignored starts and pixels.
    repeat (5) cyc(0, 0, 1);
    cyc(1, 1, 1);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int d = 0; d < 3; d++) expect_idle_zero(d, "start_with_reset");
    cyc(0, 1, 1);
    repeat (10) cyc(0, 0, 1);
    cyc(0, 1, 1);
    repeat (25) cyc(0, 0, 1);
    frame_tail_and_reset();
    $display("frame with stray start: windows a=%0d b=%0d", cnt_wv[0] - base_wv[0], cnt_wv[1] - base_wv[1]);
    expect_wins(0, 16, "s1_stray_start");
    expect_wins(1, 4, "s2_stray_start");
    repeat (2) cyc(1, 0, 0);
    base_wv[2] = cnt_wv[2];

    // Full default-size frame.
    cyc(0, 1, 0);
    repeat (784) cyc(0, 0, 1);
    frame_tail_and_reset();
    $display("frame default: windows c=%0d", cnt_wv[2] - base_wv[2]);
    expect_wins(2, 576, "default_frame");
    expect_wins(0, 16, "s1_during_default");
    repeat (3) cyc(0, 0, 0);

    compared++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expected: got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
